// File: rtl/tff_bank_ctrl_if.sv
// Command/status bundle between the lab top-level and the TFF bank sequencer.
// The master drives commands and configuration; the slave (the sequencer)
// reports busy/done back.
interface tff_bank_ctrl_if #(
    parameter int N     = 4,
    parameter int DIV_W = 8
);
    logic             clr;
    logic             start;
    logic             stop;
    logic             load;
    logic             dir;
    logic             wrap;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     load_val;
    logic [N-1:0]     limit;
    logic             busy;
    logic             done;

    modport master (
        output clr, start, stop, load, dir, wrap, div, load_val, limit,
        input  busy, done
    );

    modport slave (
        input  clr, start, stop, load, dir, wrap, div, load_val, limit,
        output busy, done
    );
endinterface

// File: rtl/tff_bank_ctrl.sv
// Sequencer for a bank of N toggle flip-flops used as a counter.
// The T vector is combinational so the bank toggles on the same edge on which
// the controller changes state. Counting happens by toggling exactly the bits
// that change between q and the next value.
module tff_bank_ctrl #(
    parameter int N     = 4,
    parameter int DIV_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tff_bank_ctrl_if.slave       ctl,
    input  logic [N-1:0]         q,
    output logic [N-1:0]         t,
    output logic                 tff_rstn
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [DIV_W-1:0] presc_r;
    logic [DIV_W-1:0] presc_nxt_s;
    logic [N-1:0]     t_s;
    logic             tick_s;
    logic             busy_r;
    logic             done_r;

    // Up count: bit i toggles when every lower bit is 1.
    function automatic logic [N-1:0] up_vec(input logic [N-1:0] qv);
        logic [N-1:0] v;
        logic         carry;
        carry = 1'b1;
        for (int i = 0; i < N; i++) begin
            v[i]  = carry;
            carry = carry & qv[i];
        end
        return v;
    endfunction

    // Down count: bit i toggles when every lower bit is 0.
    function automatic logic [N-1:0] down_vec(input logic [N-1:0] qv);
        logic [N-1:0] v;
        logic         borrow;
        borrow = 1'b1;
        for (int i = 0; i < N; i++) begin
            v[i]   = borrow;
            borrow = borrow & ~qv[i];
        end
        return v;
    endfunction

    assign tick_s = (presc_r == ctl.div);

    // Next state, prescaler and T vector, honouring rst > clr > stop > load > start.
    always_comb begin
        state_nxt_s = state_r;
        presc_nxt_s = presc_r;
        t_s         = {N{1'b0}};
        if (rst || ctl.clr) begin
            state_nxt_s = ST_IDLE;
            presc_nxt_s = {DIV_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    presc_nxt_s = {DIV_W{1'b0}};
                    if (ctl.stop) begin
                        state_nxt_s = ST_IDLE;
                    end else if (ctl.load) begin
                        t_s = q ^ ctl.load_val;
                    end else if (ctl.start) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (ctl.stop) begin
                        state_nxt_s = ST_IDLE;
                        presc_nxt_s = {DIV_W{1'b0}};
                    end else if (tick_s) begin
                        presc_nxt_s = {DIV_W{1'b0}};
                        if (q != ctl.limit) begin
                            t_s = ctl.dir ? up_vec(q) : down_vec(q);
                        end else if (ctl.wrap) begin
                            t_s = q ^ ctl.load_val;
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
                    end else begin
                        presc_nxt_s = presc_r + {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                    presc_nxt_s = {DIV_W{1'b0}};
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    presc_nxt_s = {DIV_W{1'b0}};
                end
            endcase
        end
    end

    // State, prescaler and status flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            presc_r <= {DIV_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            presc_r <= presc_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign t        = t_s;
    assign tff_rstn = ~(rst | ctl.clr);
    assign ctl.busy = busy_r;
    assign ctl.done = done_r;

endmodule
